// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a little-endian byte stream
// (16-bit word count, then count 32-bit words) and releases the core reset
// only after every word has been written.
//
// state  | meaning
// -------+--------------------------------------------------------------
// LEN_LO | waiting for the low byte of the word count
// LEN_HI | waiting for the high byte of the word count, then range check
// DATA   | collecting the four bytes of the current word, LSB first
// WRITE  | one-cycle memory write of the assembled word
// DONE   | load complete, core released, further bytes refused
// ERROR  | count exceeded memory depth, core held in reset
module imem_loader #(
  parameter int NUM_INSTR = 1024
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load_req,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_n_rst,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  // 17 bits so a count of 65535 still compares correctly against the depth
  localparam logic [16:0] MAX_CNT = 17'(NUM_INSTR);

  state_t      state;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic        accept;
  logic [15:0] len_full;
  logic [15:0] word_idx_nxt;

  // Byte acceptance is combinational so a restart request blocks the byte on the same cycle
  always_comb begin
    in_ready     = ((state == LEN_LO) || (state == LEN_HI) || (state == DATA)) && !load_req;
    accept       = in_valid && in_ready;
    len_full     = {in_data, count[7:0]};
    word_idx_nxt = word_idx + 16'd1;
  end

  // Write port is decoded from state so a write in flight is never cut short by load_req
  always_comb begin
    imem_we    = (state == WRITE);
    imem_addr  = {14'd0, word_idx, 2'b00};
    imem_wdata = word;
  end

  // Sequencer: load_req overrides every transition and clears all progress
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= LEN_LO;
      count      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word       <= '0;
      core_n_rst <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else if (load_req) begin
      state      <= LEN_LO;
      count      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word       <= '0;
      core_n_rst <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        LEN_LO: begin
          if (accept) begin
            count[7:0] <= in_data;
            state      <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            count[15:8] <= in_data;
            if (len_full == 16'd0) begin
              state      <= DONE;
              done       <= 1'b1;
              core_n_rst <= 1'b1;
            end else if ({1'b0, len_full} > MAX_CNT) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              state    <= DATA;
              word_idx <= '0;
              byte_idx <= '0;
            end
          end
        end
        DATA: begin
          if (accept) begin
            word[{byte_idx, 3'b000} +: 8] <= in_data;
            byte_idx                      <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx_nxt;
          if (word_idx_nxt == count) begin
            state      <= DONE;
            done       <= 1'b1;
            core_n_rst <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DONE: begin
          state <= DONE;
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state <= LEN_LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streams with hand-computed writes.
module tb_imem_loader;

  logic        clk;
  logic        n_rst;
  logic        load_req;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_n_rst;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  logic [31:0] wr_addr [32];
  logic [31:0] wr_data [32];
  int          nwr     = 0;
  int          run     = 0;
  int          max_run = 0;
  int          base;

  logic [7:0]  byte_q [$];

  imem_loader #(.NUM_INSTR(1024)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_req   (load_req),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_n_rst (core_n_rst),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log: every cycle with imem_we high is one logged write; also tracks pulse width
  always @(negedge clk) begin
    if (imem_we) begin
      if (nwr < 32) begin
        wr_addr[nwr] = imem_addr;
        wr_data[nwr] = imem_wdata;
      end
      nwr = nwr + 1;
      run = run + 1;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit acc;
    bit ok;
    if (stall) begin
      in_valid = 1'b0;
      nclk();
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      acc = in_ready;
      nclk();
      if (acc) ok = 1'b1;
    end
    in_valid = 1'b0;
    chk("byte_accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic send_q(input bit stall);
    foreach (byte_q[i]) send_byte(byte_q[i], stall);
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    #1;
    chk("ready_blocked_by_load_req", {31'd0, in_ready}, 32'd0);
    nclk();
    load_req = 1'b0;
    #1;
  endtask

  initial begin
    n_rst    = 1'b0;
    load_req = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;

    // Reset values
    chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
    chk("rst_imem_we",    {31'd0, imem_we},    32'd0);
    chk("rst_imem_addr",  imem_addr,           32'd0);
    chk("rst_imem_wdata", imem_wdata,          32'd0);
    chk("rst_core_n_rst", {31'd0, core_n_rst}, 32'd0);
    chk("rst_done",       {31'd0, done},       32'd0);
    chk("rst_error",      {31'd0, error},      32'd0);
    load_req = 1'b1;
    #1;
    chk("rst_ready_with_load_req", {31'd0, in_ready}, 32'd0);
    load_req = 1'b0;
    nclk();
    n_rst = 1'b1;
    nclk();

    // Basic load at full rate
    base   = nwr;
    byte_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    send_q(1'b0);
    chk("basic_we_last",        {31'd0, imem_we},    32'd1);
    chk("basic_ready_in_write", {31'd0, in_ready},   32'd0);
    chk("basic_core_held",      {31'd0, core_n_rst}, 32'd0);
    chk("basic_done_early",     {31'd0, done},       32'd0);
    nclk();
    chk("basic_done",     {31'd0, done},       32'd1);
    chk("basic_core_rel", {31'd0, core_n_rst}, 32'd1);
    chk("basic_ready",    {31'd0, in_ready},   32'd0);
    chk("basic_nwr",      32'(nwr - base),     32'd2);
    chk("basic_addr0",    wr_addr[base],       32'h0000_0000);
    chk("basic_data0",    wr_data[base],       32'h0050_0093);
    chk("basic_addr1",    wr_addr[base+1],     32'h0000_0004);
    chk("basic_data1",    wr_data[base+1],     32'h00A0_0113);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) nclk();
    in_valid = 1'b0;
    chk("done_extra_bytes_ignored", 32'(nwr - base),     32'd2);
    chk("done_stays",               {31'd0, done},       32'd1);

    // Zero count
    pulse_load_req();
    chk("reload_done_cleared", {31'd0, done},       32'd0);
    chk("reload_core_held",    {31'd0, core_n_rst}, 32'd0);
    base   = nwr;
    byte_q = '{8'h00, 8'h00};
    send_q(1'b0);
    chk("zero_done",     {31'd0, done},       32'd1);
    chk("zero_core_rel", {31'd0, core_n_rst}, 32'd1);
    chk("zero_ready",    {31'd0, in_ready},   32'd0);
    nclk();
    chk("zero_no_write", 32'(nwr - base),     32'd0);

    // Overflow: count 1025
    pulse_load_req();
    base   = nwr;
    byte_q = '{8'h01, 8'h04};
    send_q(1'b0);
    chk("ovf_error",     {31'd0, error},      32'd1);
    chk("ovf_core_held", {31'd0, core_n_rst}, 32'd0);
    chk("ovf_ready",     {31'd0, in_ready},   32'd0);
    chk("ovf_done",      {31'd0, done},       32'd0);
    nclk();
    chk("ovf_no_write",  32'(nwr - base),     32'd0);
    pulse_load_req();
    chk("ovf_error_cleared", {31'd0, error},    32'd0);
    chk("ovf_ready_again",   {31'd0, in_ready}, 32'd1);

    // Boundary: count exactly 1024 is legal
    byte_q = '{8'h00, 8'h04};
    send_q(1'b0);
    chk("max_count_no_error", {31'd0, error},    32'd0);
    chk("max_count_ready",    {31'd0, in_ready}, 32'd1);
    pulse_load_req();

    // Stalled source
    base    = nwr;
    max_run = 0;
    byte_q  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    send_q(1'b1);
    nclk();
    chk("stall_nwr",   32'(nwr - base),  32'd2);
    chk("stall_addr0", wr_addr[base],    32'h0000_0000);
    chk("stall_data0", wr_data[base],    32'h0050_0093);
    chk("stall_addr1", wr_addr[base+1],  32'h0000_0004);
    chk("stall_data1", wr_data[base+1],  32'h00A0_0113);
    chk("stall_pulse_width", 32'(max_run), 32'd1);
    chk("stall_done",  {31'd0, done},    32'd1);

    // Abort mid-word
    pulse_load_req();
    base   = nwr;
    byte_q = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_q(1'b0);
    pulse_load_req();
    chk("abort_wdata_cleared", imem_wdata, 32'd0);
    byte_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_q(1'b0);
    nclk();
    chk("abort_nwr",   32'(nwr - base), 32'd1);
    chk("abort_addr0", wr_addr[base],   32'h0000_0000);
    chk("abort_data0", wr_data[base],   32'h4433_2211);
    chk("abort_done",  {31'd0, done},   32'd1);

    // Reset mid-load, asynchronously between edges
    pulse_load_req();
    byte_q = '{8'h02, 8'h00, 8'h11, 8'h22};
    send_q(1'b0);
    chk("midrst_partial_word", imem_wdata, 32'h0000_2211);
    #2;
    n_rst = 1'b0;
    #1;
    chk("midrst_wdata",    imem_wdata,          32'd0);
    chk("midrst_addr",     imem_addr,           32'd0);
    chk("midrst_we",       {31'd0, imem_we},    32'd0);
    chk("midrst_core",     {31'd0, core_n_rst}, 32'd0);
    chk("midrst_done",     {31'd0, done},       32'd0);
    chk("midrst_error",    {31'd0, error},      32'd0);
    chk("midrst_ready",    {31'd0, in_ready},   32'd1);
    nclk();
    n_rst = 1'b1;
    nclk();
    base   = nwr;
    byte_q = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_q(1'b0);
    nclk();
    chk("postrst_nwr",   32'(nwr - base),      32'd1);
    chk("postrst_addr0", wr_addr[base],        32'h0000_0000);
    chk("postrst_data0", wr_data[base],        32'hEFBE_ADDE);
    chk("postrst_core",  {31'd0, core_n_rst},  32'd1);
    chk("postrst_done",  {31'd0, done},        32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
